// File: rtl/alu_op_dispatch_if.sv
// Handshake and ALU-control bundle between the upstream requester, the dispatch
// buffer and the ALU.
interface alu_op_dispatch_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_funct;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] aluSrc1;
  logic [31:0] aluSrc2;
  logic        invertA;
  logic        invertB;
  logic [1:0]  operation;

  modport slave (
    input  in_valid, in_funct, in_src1, in_src2, out_ready,
    output in_ready, out_valid, aluSrc1, aluSrc2, invertA, invertB, operation
  );

  modport master (
    output in_valid, in_funct, in_src1, in_src2, out_ready,
    input  in_ready, out_valid, aluSrc1, aluSrc2, invertA, invertB, operation
  );
endinterface

// File: rtl/alu_op_dispatch.sv
// Decodes ALU funct codes at acceptance and buffers the resulting operand/control
// entries in a 2-entry FIFO presented to the ALU; flags undefined functs stickily.
module alu_op_dispatch #(
  parameter int unsigned DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_op_dispatch_if.slave   bus,
  output logic               illegal,
  output logic [7:0]         issued_cnt
);

  typedef struct packed {
    logic [31:0] src1;
    logic [31:0] src2;
    logic        inv_a;
    logic        inv_b;
    logic [1:0]  op;
  } entry_t;

  entry_t      mem_q [DEPTH];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q, count_d;
  logic        illegal_q, illegal_d;
  logic [7:0]  issued_q, issued_d;

  logic        dec_legal, dec_inv_a, dec_inv_b;
  logic [1:0]  dec_op;
  logic        accept, push, pop;
  entry_t      head;

  always_comb begin
    dec_legal = 1'b1;
    dec_inv_a = 1'b0;
    dec_inv_b = 1'b0;
    dec_op    = 2'b00;
    case (bus.in_funct)
      4'b0000: dec_op = 2'b00;
      4'b0001: dec_op = 2'b01;
      4'b0010: dec_op = 2'b10;
      4'b0110: begin dec_inv_b = 1'b1; dec_op = 2'b10; end
      4'b0111: begin dec_inv_b = 1'b1; dec_op = 2'b11; end
      4'b1100: begin dec_inv_a = 1'b1; dec_inv_b = 1'b1; dec_op = 2'b00; end
      default: dec_legal = 1'b0;
    endcase
  end

  // Readiness depends only on occupancy, never on out_ready.
  assign bus.in_ready  = (count_q != 2'd2);
  assign bus.out_valid = (count_q != 2'd0);

  assign accept = bus.in_valid & bus.in_ready;
  assign push   = accept & dec_legal;
  assign pop    = bus.out_valid & bus.out_ready;

  always_comb begin
    count_d   = count_q;
    illegal_d = illegal_q | (accept & ~dec_legal);
    issued_d  = issued_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
    if (pop && (issued_q != 8'hff)) begin
      issued_d = issued_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      illegal_q <= 1'b0;
      issued_q  <= 8'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= '{src1: bus.in_src1, src2: bus.in_src2,
                             inv_a: dec_inv_a, inv_b: dec_inv_b, op: dec_op};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q   <= count_d;
      illegal_q <= illegal_d;
      issued_q  <= issued_d;
    end
  end

  // Fields read as zero whenever the buffer is empty, including during reset.
  assign head          = bus.out_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.aluSrc1   = head.src1;
  assign bus.aluSrc2   = head.src2;
  assign bus.invertA   = head.inv_a;
  assign bus.invertB   = head.inv_b;
  assign bus.operation = head.op;

  assign illegal    = illegal_q;
  assign issued_cnt = issued_q;

endmodule

// File: doc/alu_op_dispatch.md
ALU_OP_DISPATCH -- requirements
Module: alu_op_dispatch

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of operation-buffer entries; the only legal value is 2.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  upstream request present.
REQ-005 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL have port in_funct  input  4  operation code.
REQ-007 SHALL have port in_src1  input  32  operand A.
REQ-008 SHALL have port in_src2  input  32  operand B.
REQ-009 SHALL have port out_valid  output  1  head entry presented to the ALU.
REQ-010 SHALL have port out_ready  input  1  ALU side consumes the head entry.
REQ-011 SHALL have port aluSrc1  output  32  operand A of the head entry.
REQ-012 SHALL have port aluSrc2  output  32  operand B of the head entry.
REQ-013 SHALL have port invertA  output  1  ALU invert-A control.
REQ-014 SHALL have port invertB  output  1  ALU invert-B control.
REQ-015 SHALL have port operation  output  2  ALU operation select.
REQ-016 SHALL have port illegal  output  1  sticky flag: an undefined funct has been received.
REQ-017 SHALL have port issued_cnt  output  8  count of entries consumed, saturating.

Function
REQ-018 SHALL accept a request on a rising edge with in_valid=1 and in_ready=1.
REQ-019 SHALL decode funct at acceptance: 0000 AND -> invA=0 invB=0 op=00; 0001 OR -> 0,0,01; 0010 ADD -> 0,0,10; 0110 SUB -> 0,1,10; 0111 SLT -> 0,1,11; 1100 NOR -> 1,1,00.
REQ-020 SHALL store {src1, src2, invA, invB, op} in a 2-entry FIFO for legal funct values.
REQ-021 SHALL, for any other funct, accept the request without enqueuing it and set illegal=1 on the same edge.
REQ-022 SHALL drive in_ready=1 when occupancy <2, and 0 when occupancy =2; in_ready SHALL NOT depend on out_ready.
REQ-023 SHALL drive out_valid=1 exactly when occupancy >=1.
REQ-024 SHALL drive the ALU fields from the head entry when out_valid=1, and all zeros when empty.
REQ-025 SHALL pop the head on a rising edge with out_valid=1 and out_ready=1.
REQ-026 SHALL provide one-cycle latency: an entry accepted at edge N into an empty FIFO is presented from edge N onward (out_valid high in cycle N+1).
REQ-027 SHALL leave occupancy unchanged on a simultaneous push and pop at occupancy 1, presenting the new entry after the edge.
REQ-028 SHALL pop at occupancy 2 without a push (in_ready=0), leaving the second entry at head in order.
REQ-029 SHALL preserve strict FIFO order; the read and write pointers are 1 bit each and wrap 1->0.
REQ-030 SHALL hold outputs stable while out_valid=1 and out_ready=0.
REQ-031 SHALL increment issued_cnt by 1 per pop, saturating at 255.
REQ-032 SHALL keep illegal at 1 until reset.

Reset
REQ-033 SHALL, while rst_n=0, immediately force occupancy 0, both pointers 0, out_valid=0, all ALU fields 0, illegal=0, issued_cnt=0; in_ready=1.
REQ-034 SHALL discard all buffered entries on reset mid-operation; no pop or issue count results from them.
REQ-035 SHALL accept new requests on the first rising edge with rst_n=1.

Verification
REQ-036 SHALL cover: push funct 0110, src1=5, src2=3 into empty FIFO, out_ready=1 -> next cycle out_valid=1, aluSrc1=5, aluSrc2=3, invertA=0, invertB=1, operation=10; popped at that edge, issued_cnt=1.
REQ-037 SHALL cover: out_ready=0, push ADD then OR -> in_ready=0 after second push; with out_ready=1, ADD presented, then OR, then out_valid=0.
REQ-038 SHALL cover: push funct 1111 -> illegal=1, out_valid stays 0, illegal held across subsequent legal traffic.
REQ-039 SHALL cover: occupancy 1, simultaneous push NOR and pop -> occupancy stays 1, next presented invertA=1, invertB=1, operation=00.
REQ-040 SHALL cover: rst_n asserted asynchronously mid-cycle with 2 entries buffered -> out_valid=0, in_ready=1, all fields 0 before the next clock edge.
REQ-041 SHALL cover: 260 consecutive pops -> issued_cnt saturates at 255.
